// File: rtl/afu_mmio_csr_if.sv
// MMIO request/response bundle between the CCI-P register stage (master) and the AFU CSR block (slave).
// Carries only the rx.c0 MMIO fields and tx c0/c1/c2 signals the CSR block actually uses.
interface afu_mmio_csr_if;
    logic        rxMmioRdValid;
    logic        rxMmioWrValid;
    logic [15:0] rxAddress;
    logic [1:0]  rxLength;
    logic [8:0]  rxTid;
    logic [63:0] rxData;

    logic        txC0Valid;
    logic        txC1Valid;
    logic        txMmioRdValid;
    logic [8:0]  txTid;
    logic [63:0] txData;

    modport master (
        output rxMmioRdValid, rxMmioWrValid, rxAddress, rxLength, rxTid, rxData,
        input  txC0Valid, txC1Valid, txMmioRdValid, txTid, txData
    );

    modport slave (
        input  rxMmioRdValid, rxMmioWrValid, rxAddress, rxLength, rxTid, rxData,
        output txC0Valid, txC1Valid, txMmioRdValid, txTid, txData
    );
endinterface

// File: rtl/afu_mmio_csr.sv
// MMIO CSR front end: two-stage capture/commit pipeline holding the DFH/ID block and scratch registers.
// Optional MMIO_STATS_EN adds a read/write counter register at word address 0x40.
module afu_mmio_csr #(
    parameter int          NUM_SCRATCH = 4,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0
) (
    input logic           clock,
    input logic           reset,
    afu_mmio_csr_if.slave mmio
);

    localparam logic [63:0] DFH        = 64'h1000_0100_0000_0000;
    localparam logic [3:0]  NumScratch = 4'(NUM_SCRATCH);

    logic        rdValid_q;
    logic        wrValid_q;
    logic [15:0] addr_q;
    logic [1:0]  len_q;
    logic [8:0]  tid_q;
    logic [63:0] data_q;

    logic [63:0] scratch_q [NUM_SCRATCH];
    logic [63:0] scratch_d [NUM_SCRATCH];

    logic        rspValid_q;
    logic [8:0]  rspTid_q;
    logic [63:0] rspData_q;

    logic [14:0] slot;
    logic        scratchHit;
    logic [2:0]  scratchIdx;
    logic        wrAccept;
    logic [63:0] regValue;
    logic [63:0] rdData;
    logic [63:0] wrValue;

    // Stage 1: a simultaneous write suppresses the read so no response is produced
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdValid_q <= 1'b0;
            wrValid_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            tid_q     <= '0;
            data_q    <= '0;
        end else begin
            rdValid_q <= mmio.rxMmioRdValid & ~mmio.rxMmioWrValid;
            wrValid_q <= mmio.rxMmioWrValid;
            addr_q    <= mmio.rxAddress;
            len_q     <= mmio.rxLength;
            tid_q     <= mmio.rxTid;
            data_q    <= mmio.rxData;
        end
    end

    // Registers are 8 bytes wide, so the even/odd word bit only selects a half
    assign slot       = addr_q[15:1];
    assign scratchIdx = slot[2:0];
    assign scratchHit = (slot[14:3] == 12'd2) && ({1'b0, slot[2:0]} < NumScratch);
    assign wrAccept   = wrValid_q && !len_q[1];

`ifdef MMIO_STATS_EN
    logic [31:0] rdCount_q;
    logic [31:0] rdCount_d;
    logic [31:0] wrCount_q;
    logic [31:0] wrCount_d;
    logic        statsHit;

    assign statsHit = (slot == 15'h0020);

    always_comb begin
        rdCount_d = rdCount_q;
        wrCount_d = wrCount_q;
        if (wrAccept && statsHit) begin
            rdCount_d = '0;
            wrCount_d = '0;
        end else begin
            if (wrValid_q && (wrCount_q != 32'hFFFF_FFFF)) begin
                wrCount_d = wrCount_q + 32'd1;
            end
            if (rdValid_q && (rdCount_q != 32'hFFFF_FFFF)) begin
                rdCount_d = rdCount_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else begin
            rdCount_q <= rdCount_d;
            wrCount_q <= wrCount_d;
        end
    end
`endif

    always_comb begin
        regValue = '0;
        case (slot)
            15'd0:   regValue = DFH;
            15'd1:   regValue = AFU_ID_L;
            15'd2:   regValue = AFU_ID_H;
            default: regValue = '0;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (scratchHit && (scratchIdx == 3'(i))) begin
                regValue = scratch_q[i];
            end
        end
`ifdef MMIO_STATS_EN
        if (statsHit) begin
            regValue = {wrCount_q, rdCount_q};
        end
`endif
    end

    always_comb begin
        rdData = regValue;
        if (len_q == 2'd0) begin
            rdData = addr_q[0] ? {32'h0, regValue[63:32]} : {32'h0, regValue[31:0]};
        end
    end

    always_comb begin
        wrValue = data_q;
        if (!len_q[0]) begin
            wrValue = addr_q[0] ? {data_q[31:0], regValue[31:0]} : {regValue[63:32], data_q[31:0]};
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (wrAccept && scratchHit && (scratchIdx == 3'(i))) begin
                scratch_d[i] = wrValue;
            end
        end
    end

    // Stage 2: scratch commit and read response share the same edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
            rspValid_q <= 1'b0;
            rspTid_q   <= '0;
            rspData_q  <= '0;
        end else begin
            scratch_q  <= scratch_d;
            rspValid_q <= rdValid_q;
            if (rdValid_q) begin
                rspTid_q  <= tid_q;
                rspData_q <= rdData;
            end
        end
    end

    assign mmio.txC0Valid     = 1'b0;
    assign mmio.txC1Valid     = 1'b0;
    assign mmio.txMmioRdValid = rspValid_q;
    assign mmio.txTid         = rspTid_q;
    assign mmio.txData        = rspData_q;

endmodule

// File: tb/tb_afu_mmio_csr.sv
// Bench for afu_mmio_csr: directed and random MMIO traffic against a register-map model,
// with a queue-based scoreboard checking every read completion for tid, data and arrival cycle.
module tb_afu_mmio_csr;

    localparam int          NS      = 4;
    localparam logic [63:0] ID_L    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H    = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH_VAL = 64'h1000_0100_0000_0000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    afu_mmio_csr_if mmio ();

    afu_mmio_csr #(
        .NUM_SCRATCH (NS),
        .AFU_ID_L    (ID_L),
        .AFU_ID_H    (ID_H)
    ) dut (
        .clock (clock),
        .reset (reset),
        .mmio  (mmio)
    );

    always #5 clock = ~clock;

    int cycle  = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clock) cycle <= cycle + 1;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cycle;
    } exp_t;

    exp_t expQ[$];

    logic [63:0] modelScratch [NS];
    logic [31:0] modelRd;
    logic [31:0] modelWr;

    task automatic modelReset();
        for (int i = 0; i < NS; i++) modelScratch[i] = '0;
        modelRd = '0;
        modelWr = '0;
    endtask

    // Register map as seen by software, one 64-bit value per even word address
    function automatic logic [63:0] modelRegister(input logic [15:0] addr);
        int slot = int'(addr >> 1);
        if (slot == 0) return DFH_VAL;
        if (slot == 1) return ID_L;
        if (slot == 2) return ID_H;
        if (slot >= 16 && slot < 16 + NS) return modelScratch[slot - 16];
`ifdef MMIO_STATS_EN
        if (slot == 32) return {modelWr, modelRd};
`endif
        return 64'h0;
    endfunction

    task automatic modelWrite(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
        int          slot = int'(addr >> 1);
        logic [63:0] old;
`ifdef MMIO_STATS_EN
        if (len < 2 && slot == 32) begin
            modelRd = '0;
            modelWr = '0;
            return;
        end
`endif
        if (modelWr != 32'hFFFF_FFFF) modelWr = modelWr + 1;
        if (len >= 2) return;
        if (slot >= 16 && slot < 16 + NS) begin
            old = modelScratch[slot - 16];
            if (len == 1)
                modelScratch[slot - 16] = data;
            else if (addr[0])
                modelScratch[slot - 16] = (old & 64'h0000_0000_FFFF_FFFF) | ({32'h0, data[31:0]} << 32);
            else
                modelScratch[slot - 16] = (old & 64'hFFFF_FFFF_0000_0000) | {32'h0, data[31:0]};
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyIdle();
        @(posedge clock);
        #1;
        mmio.rxMmioRdValid = 1'b0;
        mmio.rxMmioWrValid = 1'b0;
    endtask

    // One request cycle; reads push their expected completion two cycles out
    task automatic applyStimulus(input bit rd, input bit wr, input logic [15:0] addr,
                                 input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        exp_t        e;
        logic [63:0] value;
        @(posedge clock);
        #1;
        mmio.rxMmioRdValid = rd;
        mmio.rxMmioWrValid = wr;
        mmio.rxAddress     = addr;
        mmio.rxLength      = len;
        mmio.rxTid         = tid;
        mmio.rxData        = data;
        if (wr) begin
            modelWrite(addr, len, data);
        end else if (rd) begin
            value = modelRegister(addr);
            if (len == 0) value = addr[0] ? (value >> 32) : (value & 64'h0000_0000_FFFF_FFFF);
            e.tid   = tid;
            e.data  = value;
            e.cycle = cycle + 2;
            expQ.push_back(e);
            if (modelRd != 32'hFFFF_FFFF) modelRd = modelRd + 1;
        end
    endtask

    task automatic applyResetDuringRead();
        @(posedge clock);
        #1;
        mmio.rxMmioRdValid = 1'b1;
        mmio.rxMmioWrValid = 1'b0;
        mmio.rxAddress     = 16'h0020;
        mmio.rxLength      = 2'd1;
        mmio.rxTid         = 9'h055;
        @(posedge clock);
        #1;
        mmio.rxMmioRdValid = 1'b0;
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        checkOutput("reset drops rsp", {63'h0, mmio.txMmioRdValid}, 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            checkOutput("c0/c1 tie-off", {62'h0, mmio.txC0Valid, mmio.txC1Valid}, 64'h0);
            if (mmio.txMmioRdValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected rsp: got tid %h data %h, expected no response", mmio.txTid, mmio.txData);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rsp cycle", 64'(cycle), 64'(e.cycle));
                    checkOutput("rsp tid", {55'h0, mmio.txTid}, {55'h0, e.tid});
                    checkOutput("rsp data", mmio.txData, e.data);
                end
            end else if (expQ.size() > 0 && expQ[0].cycle <= cycle) begin
                e = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing rsp: got none, expected tid %h data %h", e.tid, e.data);
            end
        end
    end

    initial begin
        logic [15:0] pool [16] = '{16'h00, 16'h01, 16'h02, 16'h05, 16'h06, 16'h08, 16'h09, 16'h20,
                                   16'h21, 16'h22, 16'h25, 16'h26, 16'h27, 16'h28, 16'h40, 16'h7E};
        logic [15:0] addr;
        int          r;

        mmio.rxMmioRdValid = 1'b0;
        mmio.rxMmioWrValid = 1'b0;
        mmio.rxAddress     = '0;
        mmio.rxLength      = '0;
        mmio.rxTid         = '0;
        mmio.rxData        = '0;
        modelReset();

        repeat (3) @(negedge clock);
        checkOutput("reset rsp valid", {63'h0, mmio.txMmioRdValid}, 64'h0);
        checkOutput("reset rsp tid", {55'h0, mmio.txTid}, 64'h0);
        checkOutput("reset rsp data", mmio.txData, 64'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        applyStimulus(1, 0, 16'h0000, 2'd1, 9'h01A, 64'h0);
        repeat (3) applyIdle();

        applyStimulus(0, 1, 16'h0020, 2'd1, 9'h000, 64'hDEAD_BEEF_0123_4567);
        applyStimulus(1, 0, 16'h0020, 2'd1, 9'h002, 64'h0);
        applyStimulus(0, 1, 16'h0023, 2'd0, 9'h000, 64'h0000_0000_CAFE_F00D);
        applyStimulus(1, 0, 16'h0022, 2'd0, 9'h003, 64'h0);
        applyStimulus(1, 0, 16'h0023, 2'd0, 9'h004, 64'h0);

        applyStimulus(1, 0, 16'h0002, 2'd1, 9'h001, 64'h0);
        applyStimulus(1, 0, 16'h0004, 2'd1, 9'h002, 64'h0);
        applyStimulus(1, 0, 16'h0006, 2'd1, 9'h003, 64'h0);
        applyStimulus(1, 0, 16'h007E, 2'd1, 9'h004, 64'h0);

        applyStimulus(1, 0, 16'h0001, 2'd2, 9'h010, 64'h0);
        applyStimulus(0, 1, 16'h0022, 2'd2, 9'h000, 64'h1111_2222_3333_4444);
        applyStimulus(1, 0, 16'h0022, 2'd1, 9'h011, 64'h0);
        applyStimulus(1, 1, 16'h0024, 2'd1, 9'h012, 64'h5555_6666_7777_8888);
        applyStimulus(1, 0, 16'h0024, 2'd1, 9'h013, 64'h0);
        repeat (4) applyIdle();

        applyResetDuringRead();
        applyStimulus(1, 0, 16'h0020, 2'd1, 9'h020, 64'h0);
        applyStimulus(1, 0, 16'h0022, 2'd1, 9'h021, 64'h0);

        applyStimulus(0, 1, 16'h0040, 2'd1, 9'h000, 64'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'h0026, 2'd1, 9'h000, 64'(i + 1));
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 16'h0002, 2'd1, 9'(i + 9'h30), 64'h0);
        applyStimulus(1, 0, 16'h0040, 2'd1, 9'h040, 64'h0);
        applyStimulus(0, 1, 16'h0040, 2'd1, 9'h000, 64'h0);
        applyStimulus(1, 0, 16'h0040, 2'd1, 9'h041, 64'h0);
        repeat (2) applyIdle();

        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 99);
            addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : pool[$urandom_range(0, 15)];
            if (r < 35)
                applyStimulus(1, 0, addr, 2'($urandom_range(0, 2)), 9'($urandom), 64'h0);
            else if (r < 70)
                applyStimulus(0, 1, addr, 2'($urandom_range(0, 2)), 9'($urandom), {$urandom, $urandom});
            else if (r < 73)
                applyStimulus(1, 1, addr, 2'($urandom_range(0, 2)), 9'($urandom), {$urandom, $urandom});
            else
                applyIdle();
        end

        repeat (5) applyIdle();
        checkOutput("queue drained", 64'(expQ.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
